// File: rtl/separador_serial_pkg.sv
// Shared definitions for the serial word splitter.
//   estado_t    : handshake FSM state encoding (OCIOSO=0, EMITINDO=1)
//   MODO_MSB/LSB: slice-order selector values
//   clog2_min1  : ceil(log2(n)), never less than 1, for index widths
package separador_serial_pkg;

  typedef enum logic {
    OCIOSO   = 1'b0,
    EMITINDO = 1'b1
  } estado_t;

  localparam logic MODO_MSB = 1'b0;
  localparam logic MODO_LSB = 1'b1;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/separador_serial_seletor_fatia.sv
// Combinational slice extractor.
//   palavra_i : full word
//   indice_i  : emission index of the wanted slice (0-based)
//   modo_i    : MODO_MSB -> index 0 is the top slice, MODO_LSB -> bottom slice
//   fatia_o   : selected LARGURA_SAIDA-bit slice
module seletor_fatia
  import separador_serial_pkg::*;
#(
  parameter int LARGURA_ENTRADA = 32,
  parameter int LARGURA_SAIDA   = 16,
  parameter int LARGURA_IDX     = 1
) (
  input  logic [LARGURA_ENTRADA-1:0] palavra_i,
  input  logic [LARGURA_IDX-1:0]     indice_i,
  input  logic                       modo_i,
  output logic [LARGURA_SAIDA-1:0]   fatia_o
);

  localparam int NUM_FATIAS = LARGURA_ENTRADA / LARGURA_SAIDA;

  // Physical slice position counted from the LSB end of the word.
  logic [LARGURA_IDX-1:0] posicao;

  always_comb begin
    if (modo_i == MODO_LSB) posicao = indice_i;
    else                    posicao = LARGURA_IDX'(NUM_FATIAS - 1) - indice_i;
  end

  // Constant part-selects keep the mux free of variable-width arithmetic.
  always_comb begin
    fatia_o = '0;
    for (int k = 0; k < NUM_FATIAS; k++) begin
      if (posicao == LARGURA_IDX'(k)) fatia_o = palavra_i[k*LARGURA_SAIDA +: LARGURA_SAIDA];
    end
  end

endmodule

// File: rtl/separador_serial.sv
// Serial word splitter: captures one word from one of NUM_CANAIS channels
// and emits it as LARGURA_ENTRADA/LARGURA_SAIDA slices over a valid/ready
// output, MSB-first or LSB-first per word.
//   clk, rst_n        : clock, asynchronous active-low reset
//   entradas          : concatenated channel words (channel c at c*LARGURA_ENTRADA)
//   seletor_entrada   : channel captured on accept
//   modo_ordem        : 0 = MSB slice first, 1 = LSB slice first
//   entrada_valida/entrada_pronta : input handshake
//   descartar         : synchronous flush of the word in progress
//   saida/saida_valida/saida_pronta : output slice handshake
//   indice_fatia      : emission index of the current slice
//   ultima_fatia      : current slice is the last of the word
//   erro_canal        : captured selector was out of range
module separador_serial
  import separador_serial_pkg::*;
#(
  parameter int LARGURA_ENTRADA = 32,
  parameter int LARGURA_SAIDA   = 16,
  parameter int NUM_CANAIS      = 2,
  parameter int LARGURA_SEL     = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CANAIS*LARGURA_ENTRADA-1:0]  entradas,
  input  logic [LARGURA_SEL-1:0]                 seletor_entrada,
  input  logic                                   modo_ordem,
  input  logic                                   entrada_valida,
  output logic                                   entrada_pronta,
  input  logic                                   descartar,
  output logic [LARGURA_SAIDA-1:0]               saida,
  output logic                                   saida_valida,
  input  logic                                   saida_pronta,
  output logic [clog2_min1(LARGURA_ENTRADA/LARGURA_SAIDA)-1:0] indice_fatia,
  output logic                                   ultima_fatia,
  output logic                                   erro_canal
);

  localparam int NUM_FATIAS  = LARGURA_ENTRADA / LARGURA_SAIDA;
  localparam int LARGURA_IDX = clog2_min1(NUM_FATIAS);
  localparam logic [LARGURA_IDX-1:0] IDX_ULTIMA = LARGURA_IDX'(NUM_FATIAS - 1);

  if (LARGURA_SAIDA < 1 || NUM_CANAIS < 1 ||
      (LARGURA_ENTRADA % LARGURA_SAIDA) != 0 ||
      NUM_CANAIS > (1 << LARGURA_SEL)) begin : g_parametros_invalidos
    $error("separador_serial: illegal parameter combination");
  end

  estado_t                    estado_q, estado_d;
  logic [LARGURA_ENTRADA-1:0] palavra_q, palavra_d;
  logic [LARGURA_IDX-1:0]     indice_q, indice_d;
  logic                       modo_q, modo_d;
  logic                       erro_q, erro_d;

  logic [LARGURA_ENTRADA-1:0] palavra_sel;
  logic                       erro_sel;
  logic                       aceite, transfere, fatia_ultima;
  logic [LARGURA_SAIDA-1:0]   fatia;

  // Channel mux; an unmatched selector leaves the word at 0 and flags the error.
  always_comb begin
    palavra_sel = '0;
    erro_sel    = 1'b1;
    for (int c = 0; c < NUM_CANAIS; c++) begin
      if (seletor_entrada == LARGURA_SEL'(c)) begin
        palavra_sel = entradas[c*LARGURA_ENTRADA +: LARGURA_ENTRADA];
        erro_sel    = 1'b0;
      end
    end
  end

  assign saida_valida = (estado_q == EMITINDO);
  assign fatia_ultima = (indice_q == IDX_ULTIMA);
  assign transfere    = saida_valida & saida_pronta;

  // Ready also opens while the last slice transfers, so words chain with no bubble.
  assign entrada_pronta = rst_n & ~descartar & (~saida_valida | (transfere & fatia_ultima));
  assign aceite         = entrada_valida & entrada_pronta;

  seletor_fatia #(
    .LARGURA_ENTRADA (LARGURA_ENTRADA),
    .LARGURA_SAIDA   (LARGURA_SAIDA),
    .LARGURA_IDX     (LARGURA_IDX)
  ) u_seletor_fatia (
    .palavra_i (palavra_q),
    .indice_i  (indice_q),
    .modo_i    (modo_q),
    .fatia_o   (fatia)
  );

  // Slice-related outputs are masked in OCIOSO so idle looks clean downstream.
  assign saida        = saida_valida ? fatia : '0;
  assign ultima_fatia = saida_valida & fatia_ultima;
  assign erro_canal   = saida_valida & erro_q;
  assign indice_fatia = indice_q;

  always_comb begin
    estado_d  = estado_q;
    palavra_d = palavra_q;
    indice_d  = indice_q;
    modo_d    = modo_q;
    erro_d    = erro_q;
    if (descartar) begin
      estado_d = OCIOSO;
      indice_d = '0;
    end else if (aceite) begin
      estado_d  = EMITINDO;
      palavra_d = palavra_sel;
      indice_d  = '0;
      modo_d    = modo_ordem;
      erro_d    = erro_sel;
    end else if (transfere) begin
      if (fatia_ultima) begin
        estado_d = OCIOSO;
        indice_d = '0;
      end else begin
        indice_d = indice_q + LARGURA_IDX'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      palavra_q <= '0;
      indice_q  <= '0;
      modo_q    <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      palavra_q <= palavra_d;
      indice_q  <= indice_d;
      modo_q    <= modo_d;
      erro_q    <= erro_d;
    end
  end

endmodule

// File: doc/separador_serial.md
Name: separador_serial

Overview:
Parametrised, sequential successor of the two-channel half-word splitter in the accumulator datapath.
- Accepts one LARGURA_ENTRADA-bit word from one of NUM_CANAIS channels through a valid/ready handshake.
- Emits the word as NUM_FATIAS = LARGURA_ENTRADA/LARGURA_SAIDA slices, one per output handshake.
- Slice order is selectable per word (MSB-first or LSB-first). Sits between the Nios-side word registers and the 16-bit accumulator input.

Parameters:
- LARGURA_ENTRADA, 32, width of each input word; must be a multiple of LARGURA_SAIDA.
- LARGURA_SAIDA, 16, width of each emitted slice; must be ≥1.
- NUM_CANAIS, 2, number of input channels; must be ≥1.
- LARGURA_SEL, 1, width of the channel selector; 2**LARGURA_SEL ≥ NUM_CANAIS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- entradas  in  NUM_CANAIS*LARGURA_ENTRADA  concatenated channel words; channel c occupies [c*LARGURA_ENTRADA +: LARGURA_ENTRADA].
- seletor_entrada  in  LARGURA_SEL  channel to capture on accept.
- modo_ordem  in  1  0 = MSB slice first, 1 = LSB slice first; captured on accept.
- entrada_valida  in  1  upstream word valid.
- entrada_pronta  out  1  block can accept a word this cycle.
- descartar  in  1  synchronous flush of the word in progress.
- saida  out  LARGURA_SAIDA  current slice.
- saida_valida  out  1  saida is valid.
- saida_pronta  in  1  downstream accepts slice.
- indice_fatia  out  clog2(NUM_FATIAS) (min 1)  emission index of current slice, 0-based.
- ultima_fatia  out  1  current slice is the last of the word.
- erro_canal  out  1  captured selector was ≥ NUM_CANAIS.

Behaviour:
- States: OCIOSO, EMITINDO.
- Reset (rst_n low, asynchronous): state OCIOSO; word register, indice_fatia, modo and erro registers all 0. Outputs: saida=0, saida_valida=0, ultima_fatia=0, erro_canal=0. entrada_pronta is forced to 0 while rst_n is low.
- entrada_pronta = rst_n & ~descartar & (state==OCIOSO | (saida_valida & ultima_fatia & saida_pronta)). This is a combinational path from saida_pronta, and it enables back-to-back words with no bubble.
- Accept = entrada_valida & entrada_pronta. On accept:
  - Latch the selected channel's word, modo_ordem, and erro = (seletor_entrada ≥ NUM_CANAIS).
  - If the selector is out of range, latch word 0.
  - Set index 0 and move to EMITINDO.
- Latency: the first slice is valid in the cycle after accept.
- In EMITINDO, saida_valida=1. Slice for index k:
  - MSB-first: word[LARGURA_ENTRADA-1-k*LARGURA_SAIDA -: LARGURA_SAIDA].
  - LSB-first: word[k*LARGURA_SAIDA +: LARGURA_SAIDA].
- saida, indice_fatia and ultima_fatia are stable while saida_valida & ~saida_pronta (no change under backpressure).
- On a transfer (saida_valida & saida_pronta):
  - If not last: index+1.
  - If last with a simultaneous accept: load the new word, index 0, stay EMITINDO.
  - If last without accept: go to OCIOSO, saida_valida=0.
- ultima_fatia = (index == NUM_FATIAS-1). When NUM_FATIAS=1, every slice is last.
- descartar=1 in any state: next state OCIOSO, index 0, saida_valida 0 next cycle. No accept occurs in that cycle, because descartar also gates entrada_pronta. Registered word contents are don't-care.
- erro_canal is valid alongside every slice of the word it belongs to, and is 0 in OCIOSO.
- Transitions: OCIOSO→EMITINDO on accept. EMITINDO→EMITINDO on non-last transfer or last+accept. EMITINDO→OCIOSO on last transfer without accept, or on descartar.
- Parameter legality is checked at elaboration (generate-time error): LARGURA_ENTRADA % LARGURA_SAIDA ≠ 0 or NUM_CANAIS > 2**LARGURA_SEL.

Decomposition:
- Shared package: state encoding (OCIOSO=0, EMITINDO=1), MODO_MSB=0 / MODO_LSB=1 constants, clog2 helper function.
- One natural sub-module: seletor_fatia. It is a combinational slice extractor (word, index, modo → slice), reused by the accumulator's wide-word path.
- The handshake FSM, the capture register and channel muxing stay in separador_serial.

Test Plan:
- Defaults, channel 1 = 0xAABBCCDD, modo 0, saida_pronta=1 → slices 0xAABB (idx 0) then 0xCCDD (idx 1, ultima=1); first slice 1 cycle after accept.
- Channel 0 = 0x12345678, modo 1 → 0x5678 then 0x1234; erro_canal=0 throughout.
- Backpressure: saida_pronta low 3 cycles on slice 0 of 0xDEADBEEF → 0xDEAD held stable with valid=1, index 0; entrada_pronta=0 until the last slice transfers.
- Back-to-back: entrada_valida held high with words 0x11112222, 0x33334444 → continuous 0x1111, 0x2222, 0x3333, 0x4444 with no idle cycle; second accept occurs in the same cycle as the 0x2222 transfer.
- LARGURA_ENTRADA=64, LARGURA_SAIDA=8, NUM_CANAIS=3, LARGURA_SEL=2, seletor=3 → erro_canal=1, eight 0x00 slices, ultima on idx 7; seletor=2 with 0x0102030405060708, modo 1 → 0x08..0x01.
- descartar asserted during slice 1 of a 2-slice word, together with entrada_valida → no accept that cycle, saida_valida 0 next cycle; rst_n pulsed low mid-word → outputs immediately 0 and entrada_pronta 0 during reset, idle afterwards.
